rx_block_fifo: RTL and testbench

Block buffer between the UART receiver and the DES encryption datapath. It detects each completed 8-byte frame from the receiver (rising edge of `fr`) and packs bytes `r1`..`r8` into one 64-bit plaintext block. Blocks are queued in a small FIFO and presented to the cipher stage through a valid/ready handshake. Overflow is flagged sticky so the host can detect lost blocks.

---
 rtl/rx_block_fifo_if.sv | 24 ++
 rtl/rx_block_fifo.sv | 72 +++++++
 tb/tb_rx_block_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_fifo_if.sv
// Block-queue interface between the receiver side (frame bytes, pop handshake,
// overflow clear) and the block FIFO. The FIFO uses the slave view.
interface rx_block_fifo_if #(
  parameter int AW = 2
);
  logic          fr;
  logic [7:0]    r1, r2, r3, r4, r5, r6, r7, r8;
  logic          blk_ready;
  logic          clr_ovf;
  logic          blk_valid;
  logic [64:1]   blk_data;
  logic [AW:0]   level;
  logic          overflow;

  modport master (
    output fr, r1, r2, r3, r4, r5, r6, r7, r8, blk_ready, clr_ovf,
    input  blk_valid, blk_data, level, overflow
  );

  modport slave (
    input  fr, r1, r2, r3, r4, r5, r6, r7, r8, blk_ready, clr_ovf,
    output blk_valid, blk_data, level, overflow
  );
endinterface

// File: rtl/rx_block_fifo.sv
// rx_block_fifo: packs each completed 8-byte UART frame into a 64-bit block
// and queues it for the DES stage behind a first-word-fall-through
// valid/ready port. A block arriving while full with no pop is dropped and
// flagged in a sticky overflow bit.
module rx_block_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic            CLK,
  input logic            RST,
  rx_block_fifo_if.slave bus
);

  logic [64:1]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          fr_d;
  logic          ovf;
  logic [64:1]   frame;
  logic          valid;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // r1 is the first byte on the wire, so it lands in the top byte.
  assign frame = {bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7, bus.r8};

  assign valid = (cnt != '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign push  = bus.fr & ~fr_d;
  assign pop   = valid & bus.blk_ready;

  // A full FIFO still accepts a block when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Pointers, occupancy, edge detector and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      fr_d <= 1'b1;   // a frame flag already high at release is not a new block
    end else begin
      fr_d <= bus.fr;
      if (wr_en) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)             ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  // Block storage; contents are not reset, the occupancy count governs validity.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wp] <= frame;
  end

  assign bus.blk_valid = valid;
  assign bus.blk_data  = mem[rp];
  assign bus.level     = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_rx_block_fifo.sv
// Testbench for rx_block_fifo: a queue model tracks the blocks that should be
// held; every cycle the DUT's head, level, valid and overflow are compared
// against it, plus directed checks against literal expected values.
module tb_rx_block_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic CLK = 1'b0;
  logic RST;

  rx_block_fifo_if #(.AW(AW)) bus ();

  rx_block_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  string       phase    = "init";

  logic [63:0] sb[$];
  logic        m_fr_d;
  logic        m_ovf;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic [63:0] v);
    bus.r1 = v[63:56];
    bus.r2 = v[55:48];
    bus.r3 = v[47:40];
    bus.r4 = v[39:32];
    bus.r5 = v[31:24];
    bus.r6 = v[23:16];
    bus.r7 = v[15:8];
    bus.r8 = v[7:0];
  endtask

  // Compare DUT outputs against the model, predict the effect of the current
  // inputs, then advance one clock and settle 1 ns past the edge.
  task automatic step();
    logic        m_push;
    logic        m_pop;
    logic        m_full;
    logic [63:0] fr_val;
    logic [63:0] head;
    fr_val = {bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7, bus.r8};

    check("valid", 64'(bus.blk_valid), 64'(sb.size() != 0));
    check("level", 64'(bus.level), 64'(sb.size()));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (sb.size() != 0) check("head", 64'(bus.blk_data), sb[0]);

    m_push = bus.fr & ~m_fr_d;
    m_full = (sb.size() == DEPTH);
    m_pop  = (sb.size() != 0) && bus.blk_ready;
    if (m_pop) head = sb.pop_front();
    if (m_push) begin
      if (!m_full || m_pop) sb.push_back(fr_val);
      else                  m_ovf = 1'b1;
    end
    if (!(m_push && m_full && !m_pop) && bus.clr_ovf) m_ovf = 1'b0;
    m_fr_d = bus.fr;
    if (RST) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_fr_d = 1'b1;
    end

    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] v);
    set_frame(v);
    bus.fr = 1'b1;
    step();
    bus.fr = 1'b0;
    step();
  endtask

  task automatic drain_expect(input logic [63:0] exp0, input logic [63:0] exp1,
                              input logic [63:0] exp2, input logic [63:0] exp3);
    logic [63:0] e[4];
    e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3;
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 64'(bus.blk_data), e[i]);
      step();
    end
    bus.blk_ready = 1'b0;
    check("drained_level", 64'(bus.level), 64'd0);
    check("drained_valid", 64'(bus.blk_valid), 64'd0);
  endtask

  initial begin
    RST           = 1'b1;
    bus.fr        = 1'b0;
    bus.blk_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    set_frame(64'h0);
    m_fr_d = 1'b1;
    m_ovf  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    phase = "reset";
    check("valid", 64'(bus.blk_valid), 64'd0);
    check("level", 64'(bus.level), 64'd0);
    check("overflow", 64'(bus.overflow), 64'd0);
    step();

    // Single block, fr held high for 3 cycles -> exactly one push.
    phase = "single";
    set_frame(64'h0123456789ABCDEF);
    bus.fr = 1'b1;
    step();
    check("valid1", 64'(bus.blk_valid), 64'd1);
    check("data1", 64'(bus.blk_data), 64'h0123456789ABCDEF);
    check("level1", 64'(bus.level), 64'd1);
    step();
    step();
    check("level_held", 64'(bus.level), 64'd1);
    bus.fr = 1'b0;
    step();
    bus.blk_ready = 1'b1;
    step();
    bus.blk_ready = 1'b0;
    check("level_popped", 64'(bus.level), 64'd0);
    check("valid_popped", 64'(bus.blk_valid), 64'd0);

    // Fill and drain in order; pointers wrap across the next fill.
    phase = "fill";
    for (int i = 0; i < 4; i++) send_frame(64'(i));
    check("level_full", 64'(bus.level), 64'd4);
    drain_expect(64'h0, 64'h1, 64'h2, 64'h3);
    for (int i = 0; i < 4; i++) send_frame(64'h100 + 64'(i));
    drain_expect(64'h100, 64'h101, 64'h102, 64'h103);

    // Overflow: fifth block dropped, sticky flag, clear, set-wins.
    phase = "overflow";
    for (int i = 0; i < 4; i++) send_frame(64'h10 + 64'(i));
    send_frame(64'h55);
    check("ovf_set", 64'(bus.overflow), 64'd1);
    check("ovf_level", 64'(bus.level), 64'd4);
    send_frame(64'h56);
    bus.clr_ovf = 1'b1;
    set_frame(64'h57);
    bus.fr = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    bus.fr = 1'b0;
    check("ovf_set_wins", 64'(bus.overflow), 64'd1);
    step();
    drain_expect(64'h10, 64'h11, 64'h12, 64'h13);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // Full with simultaneous push and pop.
    phase = "full_pushpop";
    for (int i = 0; i < 4; i++) send_frame(64'h20 + 64'(i));
    set_frame(64'h99);
    bus.fr = 1'b1;
    bus.blk_ready = 1'b1;
    step();
    bus.fr = 1'b0;
    bus.blk_ready = 1'b0;
    check("level_stays", 64'(bus.level), 64'd4);
    check("no_ovf", 64'(bus.overflow), 64'd0);
    step();
    drain_expect(64'h21, 64'h22, 64'h23, 64'h99);

    // Reset mid-operation with fr high.
    phase = "mid_reset";
    for (int i = 0; i < 3; i++) send_frame(64'h30 + 64'(i));
    check("level3", 64'(bus.level), 64'd3);
    set_frame(64'h77);
    bus.fr = 1'b1;
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("level_rst", 64'(bus.level), 64'd0);
    check("valid_rst", 64'(bus.blk_valid), 64'd0);
    step();
    step();
    check("no_spurious", 64'(bus.level), 64'd0);
    bus.fr = 1'b0;
    step();
    bus.fr = 1'b1;
    step();
    check("push_after_rst", 64'(bus.level), 64'd1);
    check("data_after_rst", 64'(bus.blk_data), 64'h77);
    bus.fr = 1'b0;
    bus.blk_ready = 1'b1;
    step();
    bus.blk_ready = 1'b0;
    step();

    // Random soak against the queue model.
    phase = "soak";
    for (int c = 0; c < 10000; c++) begin
      bus.fr        = 1'($urandom_range(0, 1));
      bus.blk_ready = ($urandom_range(0, 2) == 0);
      bus.clr_ovf   = ($urandom_range(0, 15) == 0);
      set_frame({$urandom, $urandom});
      step();
    end
    bus.fr        = 1'b0;
    bus.blk_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
